// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, key-length helpers, GF(2^8) xtime and
//               the key-scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int c_WORD_BITS   = 32;
    localparam int c_BLOCK_BITS  = 128;
    localparam int c_BLOCK_WORDS = 4;

    // Key-scheduler state encoding
    typedef logic [1:0] ks_state_t;
    localparam ks_state_t c_ST_IDLE   = 2'd0;
    localparam ks_state_t c_ST_EXPAND = 2'd1;
    localparam ks_state_t c_ST_DONE   = 2'd2;

    function automatic bit key_length_ok(input int key_length);
        return (key_length == 128) || (key_length == 192) || (key_length == 256);
    endfunction

    // Number of 32-bit words in the cipher key
    function automatic int nk_of(input int key_length);
        return key_length / c_WORD_BITS;
    endfunction

    // Number of rounds
    function automatic int nr_of(input int key_length);
        return nk_of(key_length) + 6;
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : AES forward S-box, computed as the GF(2^8) multiplicative
//               inverse (a^254) followed by the affine transform.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/aes_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_scheduler
// Description : Iterative AES key expansion, one word per clock, for 128/192/
//               256-bit keys. Round keys are kept in a word store and read
//               back through a registered port.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_scheduler
    import aes_pkg::*;
#(
    parameter int KEY_LENGTH = 256
) (
    input  logic                    Clk,
    input  logic                    Nrst,
    input  logic                    Start,
    input  logic [KEY_LENGTH-1:0]   Input_key,
    output logic                    Busy,
    output logic                    Keys_valid,
    input  logic [3:0]              Rd_round,
    output logic [c_BLOCK_BITS-1:0] Rd_key
);

    localparam int         c_NK        = nk_of(KEY_LENGTH);
    localparam int         c_NR        = nr_of(KEY_LENGTH);
    localparam int         c_NWORDS    = c_BLOCK_WORDS * (c_NR + 1);
    localparam logic [5:0] c_FIRST_IDX = 6'(c_NK);
    localparam logic [5:0] c_LAST_IDX  = 6'(c_NWORDS - 1);
    localparam logic [2:0] c_POS_MAX   = 3'(c_NK - 1);
    localparam logic [3:0] c_RD_MAX    = 4'(c_NR);

    generate
        if (!key_length_ok(KEY_LENGTH)) begin : g_bad_key_length
            $error("aes_key_scheduler: KEY_LENGTH must be 128, 192 or 256");
        end
    endgenerate

    ks_state_t   r_state;
    ks_state_t   w_state_next;
    logic [5:0]  r_idx;                 // index i of the word being produced
    logic [2:0]  r_pos;                 // i mod Nk, tracked incrementally
    logic [7:0]  r_rcon;
    logic [31:0] r_win   [c_NK];        // r_win[0] = w[i-Nk] ... r_win[Nk-1] = w[i-1]
    logic [31:0] r_store [c_NWORDS];    // word j lives in round key j/4, slot j%4

    logic        w_accept;
    logic        w_expand;
    logic        w_last;
    logic [31:0] w_prev;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_temp;
    logic [31:0] w_new;

    assign w_expand = (r_state == c_ST_EXPAND);
    assign w_last   = (r_idx == c_LAST_IDX);
    assign w_prev   = r_win[c_NK-1];

    // Next-state decode and status outputs; Start is only honoured outside EXPAND
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        Busy         = 1'b0;
        Keys_valid   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ST_EXPAND;
                end
            end
            c_ST_EXPAND: begin
                Busy = 1'b1;
                if (w_last) w_state_next = c_ST_DONE;
            end
            c_ST_DONE: begin
                Keys_valid = 1'b1;
                if (Start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ST_EXPAND;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // RotWord (right rotate by one byte in this packing) only on i mod Nk = 0
    assign w_sub_in = (r_pos == 3'd0) ? {w_prev[7:0], w_prev[31:8]} : w_prev;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_sub_in[8*b +: 8]),
                .o_byte (w_sub_out[8*b +: 8])
            );
        end
    endgenerate

    // Select the temp word: SubWord+Rcon at a key boundary, plain SubWord at
    // the mid-key point for 256-bit keys, otherwise pass w[i-1] through
    always_comb begin
        w_temp = w_prev;
        if (r_pos == 3'd0) begin
            w_temp = w_sub_out ^ {24'h000000, r_rcon};
        end else if ((c_NK == 8) && (r_pos == 3'd4)) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new = r_win[0] ^ w_temp;

    // State, word counter, Rcon and sliding window of the last Nk words
    always_ff @(posedge Clk or negedge Nrst) begin
        if (!Nrst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 6'd0;
            r_pos   <= 3'd0;
            r_rcon  <= 8'h01;
            for (int k = 0; k < c_NK; k++) r_win[k] <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx  <= c_FIRST_IDX;
                r_pos  <= 3'd0;
                r_rcon <= 8'h01;
                for (int k = 0; k < c_NK; k++) r_win[k] <= Input_key[32*k +: 32];
            end else if (w_expand) begin
                r_idx <= r_idx + 6'd1;
                r_pos <= (r_pos == c_POS_MAX) ? 3'd0 : r_pos + 3'd1;
                if (r_pos == 3'd0) r_rcon <= xtime(r_rcon);
                for (int k = 0; k < c_NK - 1; k++) r_win[k] <= r_win[k+1];
                r_win[c_NK-1] <= w_new;
            end
        end
    end

    // Round-key word store; holds no reset so it can map onto plain RAM/flops
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            for (int k = 0; k < c_NK; k++) r_store[k] <= Input_key[32*k +: 32];
        end else if (w_expand) begin
            r_store[r_idx] <= w_new;
        end
    end

    // Registered read port; indices past the last round return zero
    always_ff @(posedge Clk or negedge Nrst) begin
        if (!Nrst) begin
            Rd_key <= '0;
        end else if (Rd_round <= c_RD_MAX) begin
            Rd_key <= {r_store[{Rd_round, 2'd3}], r_store[{Rd_round, 2'd2}],
                       r_store[{Rd_round, 2'd1}], r_store[{Rd_round, 2'd0}]};
        end else begin
            Rd_key <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_scheduler
// Description : Self-checking bench running 128/192/256-bit schedulers side by
//               side against a behavioural FIPS-197 key-expansion model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_scheduler;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   rd_round = 4'd0;
    logic [127:0] key128 = '0;
    logic [191:0] key192 = '0;
    logic [255:0] key256 = '0;
    logic [2:0]   busy;
    logic [2:0]   valid;
    logic [127:0] rd_key [3];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    aes_key_scheduler #(.KEY_LENGTH(128)) u_dut128 (
        .Clk(clk), .Nrst(nrst), .Start(start), .Input_key(key128),
        .Busy(busy[0]), .Keys_valid(valid[0]), .Rd_round(rd_round), .Rd_key(rd_key[0]));
    aes_key_scheduler #(.KEY_LENGTH(192)) u_dut192 (
        .Clk(clk), .Nrst(nrst), .Start(start), .Input_key(key192),
        .Busy(busy[1]), .Keys_valid(valid[1]), .Rd_round(rd_round), .Rd_key(rd_key[1]));
    aes_key_scheduler #(.KEY_LENGTH(256)) u_dut256 (
        .Clk(clk), .Nrst(nrst), .Start(start), .Input_key(key256),
        .Busy(busy[2]), .Keys_valid(valid[2]), .Rd_round(rd_round), .Rd_key(rd_key[2]));

    task automatic check(input string name, input int inst,
                         input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d got %h expected %h", name, inst, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // S-box table built from the generator-3 walk of GF(2^8)
    initial begin
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    end

    function automatic logic [7:0] rcon_of(input int n);
        case (n)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] key,
                                output logic [127:0] rk [15]);
        logic [31:0] w [60];
        logic [31:0] t;
        int nr, total;
        nr = nk + 6;
        total = 4 * (nr + 1);
        for (int j = 0; j < nk; j++) w[j] = key[32*j +: 32];
        for (int j = nk; j < total; j++) begin
            t = w[j-1];
            if (j % nk == 0) t = subword({t[7:0], t[31:8]}) ^ {24'h0, rcon_of(j / nk)};
            else if (nk == 8 && j % nk == 4) t = subword(t);
            w[j] = w[j-nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk[r] = (r <= nr) ? {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]} : 128'h0;
    endtask

    function automatic int nk_tb(input int k);
        return 4 + 2 * k;
    endfunction

    function automatic logic [255:0] key_of(input int k);
        case (k)
            0: return {128'h0, key128};
            1: return {64'h0, key192};
            default: return key256;
        endcase
    endfunction

    // FIPS byte string (byte 0 leftmost) -> packed form with byte 0 at [7:0]
    function automatic logic [255:0] fips(input logic [255:0] v, input int nbytes);
        logic [255:0] o;
        o = '0;
        for (int b = 0; b < nbytes; b++) o[8*b +: 8] = v[8*(nbytes-1-b) +: 8];
        return o;
    endfunction

    logic [2:0]   m_busy = '0;
    logic [2:0]   m_valid = '0;
    logic [2:0]   m_rd_known = '1;
    logic [127:0] m_rd [3] = '{default: '0};
    int           m_left [3] = '{default: 0};
    logic [127:0] m_keys [3][15];

    always @(posedge clk or negedge nrst) begin : model
        logic [127:0] rk [15];
        if (!nrst) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k]     <= 1'b0;
                m_valid[k]    <= 1'b0;
                m_rd_known[k] <= 1'b1;
                m_rd[k]       <= '0;
                m_left[k]     <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_rd_known[k] <= m_valid[k];
                m_rd[k] <= (int'(rd_round) <= nk_tb(k) + 6) ? m_keys[k][rd_round] : 128'h0;
                if (start && !m_busy[k]) begin
                    model_expand(nk_tb(k), key_of(k), rk);
                    for (int r = 0; r < 15; r++) m_keys[k][r] <= rk[r];
                    m_busy[k]  <= 1'b1;
                    m_valid[k] <= 1'b0;
                    m_left[k]  <= 4 * (nk_tb(k) + 7) - nk_tb(k);
                end else if (m_busy[k]) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_busy[k]  <= 1'b0;
                        m_valid[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check("busy", k, 256'(busy[k]), 256'(m_busy[k]));
            check("keys_valid", k, 256'(valid[k]), 256'(m_valid[k]));
            if (m_rd_known[k]) check("rd_key", k, {128'h0, rd_key[k]}, {128'h0, m_rd[k]});
        end
    end

    // ---------------- stimulus ----------------
    function automatic int exp_cycles(input int k);
        case (k)
            0: return 40;
            1: return 46;
            default: return 52;
        endcase
    endfunction

    task automatic start_and_measure(input int again_at);
        int nbusy [3];
        int ninv [3];
        for (int k = 0; k < 3; k++) begin
            nbusy[k] = 0;
            ninv[k]  = 0;
        end
        @(negedge clk);
        #2 start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (busy[k]) nbusy[k]++;
                if (!valid[k]) ninv[k]++;
            end
            #2 start = (c + 1 == again_at);
            if (valid == 3'b111) break;
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("busy_cycles", k, 256'(nbusy[k]), 256'(exp_cycles(k)));
            check("invalid_cycles", k, 256'(ninv[k]), 256'(exp_cycles(k)));
            check("done", k, 256'(valid[k]), 256'(1));
        end
    endtask

    task automatic read_round(input logic [3:0] r);
        @(negedge clk);
        #2 rd_round = r;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [255:0] t;
        logic [255:0] k128_a, k128_b, e_a10, e_b10, e192_12, e256_14;
        k128_a  = fips(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
        k128_b  = fips(256'h000102030405060708090a0b0c0d0e0f, 16);
        e_a10   = fips(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16);
        e_b10   = fips(256'h13111d7fe3944a17f307a78b4d2b30c5, 16);
        e192_12 = fips(256'ha4970a331a78dc09c418c271e3a41d5d, 16);
        e256_14 = fips(256'h24fc79ccbf0979e9371ac23c6d68de36, 16);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_busy", k, 256'(busy[k]), 256'(0));
            check("reset_valid", k, 256'(valid[k]), 256'(0));
            check("reset_rd_key", k, {128'h0, rd_key[k]}, 256'(0));
        end
        check("sbox_01", 0, 256'(sbox[8'h01]), 256'(8'h7c));
        check("sbox_53", 0, 256'(sbox[8'h53]), 256'(8'hed));

        #2 nrst = 1'b1;
        key128 = k128_a[127:0];
        t = fips(256'h000102030405060708090a0b0c0d0e0f1011121314151617, 24);
        key192 = t[191:0];
        key256 = fips(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32);

        // Basic expansion for all three key lengths
        start_and_measure(0);
        read_round(4'd10);
        check("r10_128", 0, {128'h0, rd_key[0]}, e_a10);
        read_round(4'd0);
        check("r0_128", 0, {128'h0, rd_key[0]}, k128_a);
        read_round(4'd12);
        check("r12_192", 1, {128'h0, rd_key[1]}, e192_12);
        read_round(4'd14);
        check("r14_256", 2, {128'h0, rd_key[2]}, e256_14);
        read_round(4'd15);
        for (int k = 0; k < 3; k++) check("r15_zero", k, {128'h0, rd_key[k]}, 256'(0));
        for (int r = 1; r < 10; r++) read_round(4'(r));

        // Start pulsed again during expansion is ignored
        start_and_measure(5);
        read_round(4'd10);
        check("r10_128_again", 0, {128'h0, rd_key[0]}, e_a10);

        // Reset in the middle of an expansion
        @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk);
        #2 start = 1'b0;
        repeat (19) @(negedge clk);
        #2 nrst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("midreset_busy", k, 256'(busy[k]), 256'(0));
            check("midreset_valid", k, 256'(valid[k]), 256'(0));
        end
        #2 nrst = 1'b1;
        key128 = k128_b[127:0];
        t = fips(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24);
        key192 = t[191:0];
        key256 = fips(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);
        start_and_measure(0);
        read_round(4'd10);
        check("r10_128_newkey", 0, {128'h0, rd_key[0]}, e_b10);
        read_round(4'd12);
        read_round(4'd14);

        // Restart from DONE with another key
        key128 = k128_a[127:0];
        start_and_measure(0);
        read_round(4'd15);
        check("r15_zero_restart", 0, {128'h0, rd_key[0]}, 256'(0));
        read_round(4'd10);
        check("r10_128_restart", 0, {128'h0, rd_key[0]}, e_a10);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
